serial_add_ctrl: RTL
====================

// Module: serial_add_ctrl
// PURPOSE
//  Bit-serial adder controller. Sequences one shared Half_adder pair, wired as a full adder,
//  over WIDTH cycles to add two WIDTH-bit operands, one bit per clock, LSB first.
//  Sits between a register/bus master and the shared half-adder datapath.
//  Trades area for latency: a single adder cell replaces a WIDTH-bit ripple adder.
//  Handshake: start/busy/done.
// PARAMETERS
//  WIDTH   8   operand and result width in bits (legal: 1..32)
// PORTS
//  clk        in   1      single clock; all state updates on rising edge
//  rst        in   1      asynchronous, active-high reset
//  start      in   1      request; sampled only in IDLE
//  a          in   WIDTH  operand A; captured on the accepted start edge
//  b          in   WIDTH  operand B; captured on the accepted start edge
//  sum        out  WIDTH  result a+b mod 2^WIDTH; valid while done=1 and held afterwards
//  carry_out  out  1      carry out of bit WIDTH-1; same validity as sum
//  busy       out  1      high in SHIFT and DONE states
//  done       out  1      one-cycle pulse; result is valid
// BEHAVIOUR
//  Reset (async assert, applied immediately, not clock-gated):
//   - state=IDLE; sum=0; carry_out=0; busy=0; done=0
//   - shift registers, carry register and bit counter all cleared
//  FSM, 3 states:
//   - IDLE:  start=1 -> load a_sh<=a, b_sh<=b, c<=0, cnt<=0; go SHIFT. Otherwise stay.
//   - SHIFT: each cycle, form the full add of a_sh[0], b_sh[0], c:
//       HA1(a_sh[0], b_sh[0]) -> s1, c1
//       HA2(s1, c)            -> s,  c2
//       next carry = c1 | c2
//     Then shift a_sh and b_sh right; shift s into res[WIDTH-1] (res shifts right); c<=c1|c2;
//     cnt++. On cnt==WIDTH-1, after the update, go DONE.
//   - DONE:  sum<=res, carry_out<=c are already registered; done=1 for exactly this cycle;
//     next state IDLE.
//  Latency: start accepted at edge E -> done=1 in the cycle after edge E+WIDTH.
//   - Issue interval: WIDTH+2 cycles per operation.
//   - WIDTH=1: a single SHIFT cycle, then DONE.
//  start while busy=1 (SHIFT or DONE) is ignored, never queued.
//   - a/b changes after capture have no effect.
//  sum/carry_out update only on the SHIFT->DONE edge; they hold across IDLE until the next
//   result. No partial results are ever visible.
//  Width rules:
//   - cnt is $clog2(WIDTH)+1 bits
//   - sum wraps mod 2^WIDTH; the overflow bit appears only on carry_out
//  rst during SHIFT/DONE: the operation is aborted; all outputs return to reset values;
//   no done pulse is produced.
//  busy and done are registered outputs, decoded from state flops; no combinational path
//   from start to any output.
// STRUCTURE
//  Shared package serial_add_pkg:
//   - state encoding localparams: ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2
//   - 2'd3 is illegal; recover to IDLE
//  Datapath: instantiate the existing Half_adder module twice (ha_lo, ha_hi) plus a
//   carry OR. No new sub-module needed.
//  Control: FSM, bit counter and shift registers stay in this module.
// TESTING
//  1. WIDTH=8, a=8'h5A, b=8'h3C, start pulse -> done after 9 cycles; sum=8'h96, carry_out=0.
//  2. a=8'hFF, b=8'h01 -> sum=8'h00, carry_out=1; done high exactly 1 cycle.
//  3. start held high throughout op 1 -> exactly one op;
//     a new op accepted on the first IDLE cycle after done.
//  4. rst asserted mid-SHIFT (cycle 4) -> immediately busy=0, done=0, sum=0;
//     no done pulse follows.
//  5. Change a/b during SHIFT to 8'h00 -> result still uses the captured operands.
//  6. WIDTH=1: all 4 input pairs -> {carry_out,sum} = a+b; done 2 cycles after the start edge.
//  Exhaustive check at WIDTH=4 against the a+b reference model.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller: state encoding and
// a sizing helper for the bit counter.
package serial_add_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // 2'd3 is unreachable; the FSM steers it back to idle.
  typedef enum logic [1:0] {
    S_IDLE    = ST_IDLE,
    S_SHIFT   = ST_SHIFT,
    S_DONE    = ST_DONE,
    S_ILLEGAL = 2'd3
  } state_t;

  // Counter must hold WIDTH-1 for every legal WIDTH (1..32).
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/serial_add_ctrl_half_adder.sv
// Single half-adder cell; two of these plus an OR form the shared full adder.
module Half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: adds two WIDTH-bit operands one bit per clock,
// LSB first, through a single shared full-adder cell. start/busy/done handshake.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             busy,
  output logic             done
);

  localparam int                CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_next;
  logic             c;
  logic [CNT_W-1:0] cnt;
  logic             last_bit;

  logic             s1;
  logic             c1;
  logic             s;
  logic             c2;
  logic             carry_next;

  // Shared full adder: two half adders plus the carry OR.
  Half_adder ha_lo (
    .a (a_sh[0]),
    .b (b_sh[0]),
    .s (s1),
    .c (c1)
  );

  Half_adder ha_hi (
    .a (s1),
    .b (c),
    .s (s),
    .c (c2)
  );

  assign carry_next = c1 | c2;
  assign last_bit   = (cnt == CNT_LAST);

  // Result register shifts right, new sum bit entering at the MSB.
  always_comb begin
    res_next = (res >> 1'b1) | (WIDTH'(s) << (WIDTH - 1));
  end

  // Next-state decode; the unused encoding recovers to idle.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_SHIFT;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (last_bit) begin
          state_next = S_DONE;
        end else begin
          state_next = S_SHIFT;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // State register plus busy/done flops, loaded from the next-state decode so
  // the handshake outputs come straight from flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next == S_SHIFT) || (state_next == S_DONE);
      done  <= (state_next == S_DONE);
    end
  end

  // Operand capture, bit-serial shifting and result publication.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh      <= '0;
      b_sh      <= '0;
      res       <= '0;
      c         <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_sh <= a;
            b_sh <= b;
            c    <= 1'b0;
            cnt  <= '0;
          end
        end
        S_SHIFT: begin
          a_sh <= a_sh >> 1'b1;
          b_sh <= b_sh >> 1'b1;
          res  <= res_next;
          c    <= carry_next;
          cnt  <= cnt + CNT_ONE;
          // Outputs change only when the whole word is complete.
          if (last_bit) begin
            sum       <= res_next;
            carry_out <= carry_next;
          end
        end
        default: begin
          // DONE and the illegal encoding hold the datapath unchanged.
        end
      endcase
    end
  end

endmodule
